// File: rtl/icache_fetch_ctrl.sv
// rtl/icache_fetch_ctrl.sv - fetch-request sequencer between PC generator and ICache
//
// Holds one PC from the PC generator, issues it to the ICache through the
// valid/addr_ok/data_ok handshake with up to DEPTH requests in flight, and
// buffers returned instructions together with their PCs for decode. A flush
// cancels all fetch state; responses to cancelled requests are drained and
// dropped before fetching resumes.
//
// Optional feature macro: FETCH_PERF_EN (adds perf_req_cnt, perf_cancel_cnt,
// perf_stall_cnt outputs).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   pc_valid, pc_in, pc_ready     PC generator handshake
//   flush                         backend redirect
//   icache_valid, icache_tag,
//   icache_index, icache_offset   ICache request
//   icache_addr_ok                ICache accepted request
//   icache_data_ok, icache_rdata  in-order ICache response
//   ins_valid, ins_pc, ins_data   instruction to decode
//   de_allowin                    decode accepts
//   perf_*_cnt                    performance counters (FETCH_PERF_EN only)

module icache_fetch_ctrl #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid,
    input  logic [31:0] pc_in,
    output logic        pc_ready,
    input  logic        flush,
    output logic        icache_valid,
    output logic [19:0] icache_tag,
    output logic [6:0]  icache_index,
    output logic [4:0]  icache_offset,
    input  logic        icache_addr_ok,
    input  logic        icache_data_ok,
    input  logic [31:0] icache_rdata,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_cancel_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        ins_valid,
    output logic [31:0] ins_pc,
    output logic [31:0] ins_data,
    input  logic        de_allowin
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_CANCEL = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          req_hold_valid_q, req_hold_valid_d;
    logic [31:0]   req_pc_q;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] cancel_cnt_q, cancel_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] ptq_wr_q, ptq_wr_d, ptq_rd_q, ptq_rd_d;
    logic [AW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

    // Storage needs no reset: entries are only visible while counted valid.
    logic [31:0]   ptq_mem       [DEPTH];
    logic [31:0]   fifo_pc_mem   [DEPTH];
    logic [31:0]   fifo_data_mem [DEPTH];

    logic          state_run;
    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          accept;
    logic          issue;
    logic          resp;
    logic          pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign state_run = (state_q == ST_RUN);

    // Credits cover both outstanding requests and buffered results, so a
    // response can always be written without checking FIFO space.
    assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign credit_ok = occupancy < (CW + 1)'(DEPTH);

    // rst gates pc_ready so every output reads 0 while reset is held.
    assign pc_ready     = !rst && !req_hold_valid_q && !flush && state_run;
    assign icache_valid = req_hold_valid_q && credit_ok && !flush && state_run;

    assign icache_tag    = req_pc_q[31:12];
    assign icache_index  = req_pc_q[11:5];
    assign icache_offset = req_pc_q[4:0];

    assign accept = pc_valid && pc_ready;
    assign issue  = icache_valid && icache_addr_ok;
    // A data_ok in a flush cycle or while cancelling belongs to a dead request.
    assign resp   = icache_data_ok && state_run && !flush && (cancel_cnt_q == '0);
    assign pop    = ins_valid && de_allowin;

    assign ins_valid = (fifo_cnt_q != '0);
    assign ins_pc    = ins_valid ? fifo_pc_mem[fifo_rd_q]   : 32'h0;
    assign ins_data  = ins_valid ? fifo_data_mem[fifo_rd_q] : 32'h0;

    always_comb begin
        state_d          = state_q;
        req_hold_valid_d = req_hold_valid_q;
        inflight_d       = inflight_q;
        cancel_cnt_d     = cancel_cnt_q;
        fifo_cnt_d       = fifo_cnt_q;
        ptq_wr_d         = ptq_wr_q;
        ptq_rd_d         = ptq_rd_q;
        fifo_wr_d        = fifo_wr_q;
        fifo_rd_d        = fifo_rd_q;

        if (flush) begin
            req_hold_valid_d = 1'b0;
            inflight_d       = '0;
            fifo_cnt_d       = '0;
            ptq_wr_d         = '0;
            ptq_rd_d         = '0;
            fifo_wr_d        = '0;
            fifo_rd_d        = '0;
            // Every live request becomes one response to discard; a data_ok
            // arriving right now already retires one of them.
            if (state_run) begin
                cancel_cnt_d = inflight_q - CW'(icache_data_ok);
            end else begin
                cancel_cnt_d = cancel_cnt_q - CW'(icache_data_ok);
            end
            state_d = (cancel_cnt_d != '0) ? ST_CANCEL : ST_RUN;
        end else if (state_q == ST_CANCEL) begin
            if (icache_data_ok) begin
                cancel_cnt_d = cancel_cnt_q - CW'(1);
                if (cancel_cnt_q == CW'(1)) begin
                    state_d = ST_RUN;
                end
            end
        end else begin
            if (accept) begin
                req_hold_valid_d = 1'b1;
            end else if (issue) begin
                req_hold_valid_d = 1'b0;
            end
            inflight_d = inflight_q + CW'(issue) - CW'(resp);
            fifo_cnt_d = fifo_cnt_q + CW'(resp) - CW'(pop);
            if (issue) begin
                ptq_wr_d = ptr_inc(ptq_wr_q);
            end
            if (resp) begin
                ptq_rd_d  = ptr_inc(ptq_rd_q);
                fifo_wr_d = ptr_inc(fifo_wr_q);
            end
            if (pop) begin
                fifo_rd_d = ptr_inc(fifo_rd_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            req_hold_valid_q <= 1'b0;
            req_pc_q         <= 32'h0;
            inflight_q       <= '0;
            cancel_cnt_q     <= '0;
            fifo_cnt_q       <= '0;
            ptq_wr_q         <= '0;
            ptq_rd_q         <= '0;
            fifo_wr_q        <= '0;
            fifo_rd_q        <= '0;
        end else begin
            state_q          <= state_d;
            req_hold_valid_q <= req_hold_valid_d;
            inflight_q       <= inflight_d;
            cancel_cnt_q     <= cancel_cnt_d;
            fifo_cnt_q       <= fifo_cnt_d;
            ptq_wr_q         <= ptq_wr_d;
            ptq_rd_q         <= ptq_rd_d;
            fifo_wr_q        <= fifo_wr_d;
            fifo_rd_q        <= fifo_rd_d;
            if (accept) begin
                req_pc_q <= pc_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            ptq_mem[ptq_wr_q] <= req_pc_q;
        end
        if (resp) begin
            fifo_pc_mem[fifo_wr_q]   <= ptq_mem[ptq_rd_q];
            fifo_data_mem[fifo_wr_q] <= icache_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_req_q, perf_cancel_q, perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_req_q    <= 32'h0;
            perf_cancel_q <= 32'h0;
            perf_stall_q  <= 32'h0;
        end else begin
            if (issue) begin
                perf_req_q <= perf_req_q + 32'h1;
            end
            if (icache_data_ok && !resp) begin
                perf_cancel_q <= perf_cancel_q + 32'h1;
            end
            if (req_hold_valid_q && !icache_valid && state_run) begin
                perf_stall_q <= perf_stall_q + 32'h1;
            end
        end
    end

    assign perf_req_cnt    = perf_req_q;
    assign perf_cancel_cnt = perf_cancel_q;
    assign perf_stall_cnt  = perf_stall_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (occupancy <= (CW + 1)'(DEPTH));
            assert (!(icache_data_ok && state_run && inflight_q == '0));
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// tb/tb_icache_fetch_ctrl.sv - self-checking bench for icache_fetch_ctrl

module tb_icache_fetch_ctrl;

    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc_in;
    logic        pc_ready;
    logic        flush;
    logic        icache_valid;
    logic [19:0] icache_tag;
    logic [6:0]  icache_index;
    logic [4:0]  icache_offset;
    logic        icache_addr_ok;
    logic        icache_data_ok;
    logic [31:0] icache_rdata;
    logic        ins_valid;
    logic [31:0] ins_pc;
    logic [31:0] ins_data;
    logic        de_allowin;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_req_cnt, perf_cancel_cnt, perf_stall_cnt;
`endif

    icache_fetch_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_valid       (pc_valid),
        .pc_in          (pc_in),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .icache_valid   (icache_valid),
        .icache_tag     (icache_tag),
        .icache_index   (icache_index),
        .icache_offset  (icache_offset),
        .icache_addr_ok (icache_addr_ok),
        .icache_data_ok (icache_data_ok),
        .icache_rdata   (icache_rdata),
`ifdef FETCH_PERF_EN
        .perf_req_cnt   (perf_req_cnt),
        .perf_cancel_cnt(perf_cancel_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .ins_valid      (ins_valid),
        .ins_pc         (ins_pc),
        .ins_data       (ins_data),
        .de_allowin     (de_allowin)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        fl;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        de;
        logic        e_rdy;
        logic        e_icv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_idat;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } res_t;

    vec_t        tbl[$];
    pend_t       pend[$];
    logic [31:0] acc[$];
    res_t        sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic fl,
                         input logic aok, input logic dok, input logic [31:0] rd,
                         input logic de);
        pc_valid       = pv;
        pc_in          = pc;
        flush          = fl;
        icache_addr_ok = aok;
        icache_data_ok = dok;
        icache_rdata   = rd;
        de_allowin     = de;
    endtask

    function automatic vec_t row(input logic pv, input logic [31:0] pc, input logic fl,
                                 input logic aok, input logic dok, input logic [31:0] rd,
                                 input logic de, input logic e_rdy, input logic e_icv,
                                 input logic [31:0] e_addr, input logic e_iv,
                                 input logic [31:0] e_ipc, input logic [31:0] e_idat);
        vec_t v;
        v.pv = pv; v.pc = pc; v.fl = fl; v.aok = aok; v.dok = dok; v.rd = rd; v.de = de;
        v.e_rdy = e_rdy; v.e_icv = e_icv; v.e_addr = e_addr;
        v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_idat = e_idat;
        return v;
    endfunction

    function automatic logic [31:0] addr_out();
        return {icache_tag, icache_index, icache_offset};
    endfunction

    function automatic logic [31:0] icache_word(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0F0F;
    endfunction

    localparam logic [31:0] P0 = 32'h1C00_0000;

    initial begin
        int   live, stale_n, pend_sz;
        logic e_rdy, e_icv;
        logic pv, fl, aok, dok, de;
        logic [31:0] pc, rd;
        pend_t p;
        res_t  r;

        //   pv pc              fl aok dok rd            de  rdy icv addr            iv ipc             idat
        tbl.push_back(row(1, P0,             0, 0, 0, 32'h0,        0,  1, 0, 32'h0,          0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 1, 0, 32'h0,        0,  0, 1, P0,             0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 0, 0, 32'h0,        0,  1, 0, P0,             0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 0, 1, 32'h0280_0000,0,  1, 0, P0,             0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 0, 0, 32'h0,        1,  1, 0, P0,             1, P0,             32'h0280_0000));
        tbl.push_back(row(0, 32'h0,          0, 0, 0, 32'h0,        1,  1, 0, P0,             0, 32'h0,          32'h0));
        tbl.push_back(row(1, 32'h1C00_0020,  0, 0, 0, 32'h0,        0,  1, 0, P0,             0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 0, 0, 32'h0,        0,  0, 1, 32'h1C00_0020,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 0, 0, 32'h0,        0,  0, 1, 32'h1C00_0020,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 0, 0, 32'h0,        0,  0, 1, 32'h1C00_0020,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 1, 0, 32'h0,        0,  0, 1, 32'h1C00_0020,  0, 32'h0,          32'h0));
        tbl.push_back(row(1, 32'h1C00_0040,  0, 0, 0, 32'h0,        0,  1, 0, 32'h1C00_0020,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 1, 0, 32'h0,        0,  0, 1, 32'h1C00_0040,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          1, 0, 0, 32'h0,        0,  0, 0, 32'h1C00_0040,  0, 32'h0,          32'h0));
        tbl.push_back(row(1, 32'h1C00_1000,  0, 0, 1, 32'hDEAD_BEEF,1,  0, 0, 32'h1C00_0040,  0, 32'h0,          32'h0));
        tbl.push_back(row(1, 32'h1C00_1000,  0, 0, 0, 32'h0,        1,  0, 0, 32'h1C00_0040,  0, 32'h0,          32'h0));
        tbl.push_back(row(1, 32'h1C00_1000,  0, 0, 1, 32'hDEAD_BEEF,1,  0, 0, 32'h1C00_0040,  0, 32'h0,          32'h0));
        tbl.push_back(row(1, 32'h1C00_1000,  0, 0, 0, 32'h0,        0,  1, 0, 32'h1C00_0040,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 1, 0, 32'h0,        0,  0, 1, 32'h1C00_1000,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 0, 1, 32'h0000_0013,0,  1, 0, 32'h1C00_1000,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 0, 0, 32'h0,        1,  1, 0, 32'h1C00_1000,  1, 32'h1C00_1000,  32'h0000_0013));
        tbl.push_back(row(1, 32'h1C00_0060,  0, 0, 0, 32'h0,        0,  1, 0, 32'h1C00_1000,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 1, 0, 32'h0,        0,  0, 1, 32'h1C00_0060,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          1, 0, 1, 32'h1111_1111,0,  0, 0, 32'h1C00_0060,  0, 32'h0,          32'h0));
        tbl.push_back(row(1, P0,             0, 0, 0, 32'h0,        0,  1, 0, 32'h1C00_0060,  0, 32'h0,          32'h0));
        tbl.push_back(row(1, 32'h1C00_0004,  0, 1, 0, 32'h0,        0,  0, 1, P0,             0, 32'h0,          32'h0));
        tbl.push_back(row(1, 32'h1C00_0004,  0, 0, 0, 32'h0,        0,  1, 0, P0,             0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 1, 1, 32'h0000_00A0,0,  0, 1, 32'h1C00_0004,  0, 32'h0,          32'h0));
        tbl.push_back(row(1, 32'h1C00_0008,  0, 0, 0, 32'h0,        0,  1, 0, 32'h1C00_0004,  1, P0,             32'h0000_00A0));
        tbl.push_back(row(0, 32'h0,          0, 1, 1, 32'h0000_00A4,0,  0, 0, 32'h1C00_0008,  1, P0,             32'h0000_00A0));
        tbl.push_back(row(0, 32'h0,          0, 1, 0, 32'h0,        0,  0, 0, 32'h1C00_0008,  1, P0,             32'h0000_00A0));
        tbl.push_back(row(0, 32'h0,          0, 0, 0, 32'h0,        1,  0, 0, 32'h1C00_0008,  1, P0,             32'h0000_00A0));
        tbl.push_back(row(0, 32'h0,          0, 1, 0, 32'h0,        1,  0, 1, 32'h1C00_0008,  1, 32'h1C00_0004,  32'h0000_00A4));
        tbl.push_back(row(0, 32'h0,          0, 0, 1, 32'h0000_00A8,0,  1, 0, 32'h1C00_0008,  0, 32'h0,          32'h0));
        tbl.push_back(row(0, 32'h0,          0, 0, 0, 32'h0,        1,  1, 0, 32'h1C00_0008,  1, 32'h1C00_0008,  32'h0000_00A8));
        tbl.push_back(row(0, 32'h0,          0, 0, 0, 32'h0,        1,  1, 0, 32'h1C00_0008,  0, 32'h0,          32'h0));

        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].pv, tbl[i].pc, tbl[i].fl, tbl[i].aok, tbl[i].dok, tbl[i].rd, tbl[i].de);
            #1;
            check($sformatf("row%0d pc_ready", i),     {31'h0, pc_ready},     {31'h0, tbl[i].e_rdy});
            check($sformatf("row%0d icache_valid", i), {31'h0, icache_valid}, {31'h0, tbl[i].e_icv});
            check($sformatf("row%0d req_addr", i),     addr_out(),            tbl[i].e_addr);
            check($sformatf("row%0d ins_valid", i),    {31'h0, ins_valid},    {31'h0, tbl[i].e_iv});
            check($sformatf("row%0d ins_pc", i),       ins_pc,                tbl[i].e_ipc);
            check($sformatf("row%0d ins_data", i),     ins_data,              tbl[i].e_idat);
        end

        // Asynchronous reset while draining a cancelled request.
        @(negedge clk); drive(1, 32'h1C00_0100, 0, 0, 0, 32'h0, 0);
        @(negedge clk); drive(0, 32'h0, 0, 1, 0, 32'h0, 0);
        @(negedge clk); drive(0, 32'h0, 1, 0, 0, 32'h0, 0);
        @(negedge clk); drive(0, 32'h0, 0, 0, 0, 32'h0, 1);
        #1;
        check("cancel pc_ready", {31'h0, pc_ready}, 32'h0);
        check("cancel req_addr", addr_out(), 32'h1C00_0100);
        #2 rst = 1'b1;
        #1;
        check("rst pc_ready",     {31'h0, pc_ready},     32'h0);
        check("rst icache_valid", {31'h0, icache_valid}, 32'h0);
        check("rst req_addr",     addr_out(),            32'h0);
        check("rst ins_valid",    {31'h0, ins_valid},    32'h0);
        check("rst ins_pc",       ins_pc,                32'h0);
        check("rst ins_data",     ins_data,              32'h0);
`ifdef FETCH_PERF_EN
        check("rst perf_req",     perf_req_cnt,          32'h0);
        check("rst perf_cancel",  perf_cancel_cnt,       32'h0);
        check("rst perf_stall",   perf_stall_cnt,        32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst pc_ready", {31'h0, pc_ready}, 32'h1);

        // Randomised traffic against a queue-level model of the fetch path.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            live = 0;
            stale_n = 0;
            foreach (pend[k]) begin
                if (pend[k].stale) stale_n++;
                else live++;
            end
            pend_sz = pend.size();
            pv  = ($urandom % 4) != 0;
            pc  = $urandom & 32'hFFFF_FFFC;
            fl  = ($urandom % 40) == 0;
            aok = ($urandom % 3) != 0;
            dok = (pend_sz > 0) && (($urandom % 2) == 0);
            rd  = 32'h0;
            if (dok) rd = pend[0].stale ? $urandom : icache_word(pend[0].pc);
            de  = ($urandom % 3) != 0;
            drive(pv, pc, fl, aok, dok, rd, de);

            e_rdy = (acc.size() == 0) && !fl && (stale_n == 0);
            e_icv = (acc.size() != 0) && ((live + sb.size()) < DEPTH) && !fl && (stale_n == 0);
            #1;
            check("rnd pc_ready",     {31'h0, pc_ready},     {31'h0, e_rdy});
            check("rnd icache_valid", {31'h0, icache_valid}, {31'h0, e_icv});
            if (e_icv) check("rnd req_addr", addr_out(), acc[0]);
            check("rnd ins_valid", {31'h0, ins_valid}, {31'h0, (sb.size() != 0)});
            if (sb.size() != 0) begin
                check("rnd ins_pc",   ins_pc,   sb[0].pc);
                check("rnd ins_data", ins_data, sb[0].data);
            end

            if (sb.size() != 0 && de) sb.pop_front();
            if (dok) begin
                p = pend.pop_front();
                if (!p.stale && !fl) begin
                    r.pc   = p.pc;
                    r.data = rd;
                    sb.push_back(r);
                end
            end
            if (e_icv && aok) begin
                p.pc    = acc.pop_front();
                p.stale = 1'b0;
                pend.push_back(p);
            end
            if (e_rdy && pv) acc.push_back(pc);
            if (fl) begin
                acc.delete();
                sb.delete();
                foreach (pend[k]) pend[k].stale = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
